// File: rtl/dm_init_arb_pkg.sv
// Shared types and constants for the data-memory init/arbitration slice.
package dm_init_arb_pkg;

  localparam int unsigned DM_DEPTH   = 1024;
  localparam int unsigned DM_CW      = 10;
  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned OPW        = 3;
  localparam logic [31:0] DM_CLR_PCW = 32'h0000_0000;

  // Access size/sign codes understood by the data memory
  localparam logic [OPW-1:0] OP_WD  = 3'd0;
  localparam logic [OPW-1:0] OP_HF  = 3'd1;
  localparam logic [OPW-1:0] OP_BT  = 3'd2;
  localparam logic [OPW-1:0] OP_UHF = 3'd3;
  localparam logic [OPW-1:0] OP_UBT = 3'd4;

  typedef enum logic {
    CLR_ST = 1'b0,
    RUN_ST = 1'b1
  } state_t;

endpackage

// File: rtl/dm_init_arb_if.sv
// CPU, debug and data-memory port bundle around dm_init_arb.
interface dm_init_arb_if;
  import dm_init_arb_pkg::*;

  logic           cpu_vld;
  logic           cpu_en;
  logic [OPW-1:0] cpu_op;
  logic [AW-1:0]  cpu_ax;
  logic [DW-1:0]  cpu_x;
  logic [31:0]    cpu_pcw;
  logic           clr_req;
  logic           dbg_vld;
  logic [AW-1:0]  dbg_ax;
  logic [DW-1:0]  dbg_x;
  logic           dbg_rdy;
  logic [AW-1:0]  dm_ax;
  logic [DW-1:0]  dm_x;
  logic [OPW-1:0] dm_op;
  logic           dm_en;
  logic [31:0]    dm_pcw;
  logic           stall;
  logic           busy;

  modport master (
    output cpu_vld, cpu_en, cpu_op, cpu_ax, cpu_x, cpu_pcw, clr_req,
           dbg_vld, dbg_ax, dbg_x,
    input  dbg_rdy, dm_ax, dm_x, dm_op, dm_en, dm_pcw, stall, busy
  );

  modport slave (
    input  cpu_vld, cpu_en, cpu_op, cpu_ax, cpu_x, cpu_pcw, clr_req,
           dbg_vld, dbg_ax, dbg_x,
    output dbg_rdy, dm_ax, dm_x, dm_op, dm_en, dm_pcw, stall, busy
  );

endinterface

// File: rtl/dm_clr_cnt.sv
// Word counter for the memory clear sequence; wraps to zero after the last word.
module dm_clr_cnt #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dm_init_arb.sv
// Owns the data-memory port: zero-clear sequence, debug word writes, CPU pass-through.
// Build option: DM_INIT_SKIP_EN skips the clear after reset.
module dm_init_arb
  import dm_init_arb_pkg::*;
#(
  parameter int unsigned DEPTH   = DM_DEPTH,
  parameter int unsigned CW      = DM_CW,
  parameter logic [31:0] CLR_PCW = DM_CLR_PCW
) (
  input  logic          clk,
  input  logic          rst,
  dm_init_arb_if.slave  bus
);

`ifdef DM_INIT_SKIP_EN
  localparam state_t RST_ST   = RUN_ST;
  localparam logic   RST_BUSY = 1'b0;
`else
  localparam state_t RST_ST   = CLR_ST;
  localparam logic   RST_BUSY = 1'b1;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          unused_dbg_lsb;

  assign cnt_clr        = (state == RUN_ST);
  assign cnt_inc        = (state == CLR_ST);
  assign unused_dbg_lsb = ^bus.dbg_ax[1:0];

  dm_clr_cnt #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RST_ST;
    end else begin
      case (state)
        CLR_ST:  if (last)        state <= RUN_ST;
        RUN_ST:  if (bus.clr_req) state <= CLR_ST;
        default:                  state <= RST_ST;
      endcase
    end
  end

  // Port mux: reset hold, clear write, debug write, or CPU pass-through
  always_comb begin
    bus.dm_ax   = bus.cpu_ax;
    bus.dm_x    = bus.cpu_x;
    bus.dm_op   = bus.cpu_op;
    bus.dm_en   = bus.cpu_en & bus.cpu_vld;
    bus.dm_pcw  = bus.cpu_pcw;
    bus.stall   = 1'b0;
    bus.busy    = 1'b0;
    bus.dbg_rdy = 1'b0;
    if (!rst) begin
      bus.dm_en = 1'b0;
      bus.stall = 1'b1;
      bus.busy  = RST_BUSY;
    end else if (state == CLR_ST) begin
      bus.dm_ax  = AW'({cnt, 2'b00});
      bus.dm_x   = '0;
      bus.dm_op  = OP_WD;
      bus.dm_en  = 1'b1;
      bus.dm_pcw = CLR_PCW;
      bus.stall  = 1'b1;
      bus.busy   = 1'b1;
    end else if (bus.dbg_vld) begin
      bus.dbg_rdy = 1'b1;
      bus.dm_ax   = {bus.dbg_ax[AW-1:2], 2'b00};
      bus.dm_x    = bus.dbg_x;
      bus.dm_op   = OP_WD;
      bus.dm_en   = 1'b1;
      bus.dm_pcw  = CLR_PCW;
      bus.stall   = bus.cpu_vld;
    end
  end

endmodule

// File: tb/tb_dm_init_arb.sv
// Directed bench for dm_init_arb with a byte-lane data-memory model.
module tb_dm_init_arb;
  import dm_init_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_asrt;
  int   n_fail;
  logic [31:0] mem [0:1023];

  dm_init_arb_if bus();

  dm_init_arb u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: byte/half/word stores at the clock edge
  always @(posedge clk) begin
    if (bus.dm_en) begin
      case (bus.dm_op)
        OP_WD:          mem[bus.dm_ax[11:2]] <= bus.dm_x;
        OP_HF, OP_UHF:  mem[bus.dm_ax[11:2]][16*bus.dm_ax[1] +: 16] <= bus.dm_x[15:0];
        default:        mem[bus.dm_ax[11:2]][8*bus.dm_ax[1:0] +: 8] <= bus.dm_x[7:0];
      endcase
    end
  end

  function automatic logic [31:0] ld(input logic [31:0] ax, input logic [2:0] op);
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = mem[ax[11:2]];
    h = w[16*ax[1] +: 16];
    b = w[8*ax[1:0] +: 8];
    case (op)
      OP_HF:   return {{16{h[15]}}, h};
      OP_UHF:  return {16'h0, h};
      OP_BT:   return {{24{b[7]}}, b};
      OP_UBT:  return {24'h0, b};
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    bus.cpu_vld = 1'b0; bus.cpu_en = 1'b0; bus.cpu_op = OP_WD;
    bus.cpu_ax  = '0;   bus.cpu_x  = '0;   bus.cpu_pcw = '0;
  endtask

  task automatic cpu_acc(input logic en, input logic [2:0] op, input logic [31:0] ax,
                         input logic [31:0] x, input logic [31:0] pcw);
    bus.cpu_vld = 1'b1; bus.cpu_en = en; bus.cpu_op = op;
    bus.cpu_ax  = ax;   bus.cpu_x  = x;  bus.cpu_pcw = pcw;
  endtask

  // Runs a full clear from cnt=0; optional clr_req/dbg_vld pokes must not disturb it
  task automatic clear_run(input int poke_clr, input int poke_dbg);
    for (int i = 0; i < 1024; i++) begin
      bus.clr_req = (i == poke_clr);
      bus.dbg_vld = (i == poke_dbg);
      #2;
      chk("clr_ax", bus.dm_ax, 32'(i * 4));
      chk("clr_ctl", 32'({bus.dm_en, bus.stall, bus.busy, bus.dbg_rdy}), 32'b1110);
      chk("clr_x", bus.dm_x, 32'h0);
      step();
    end
    bus.clr_req = 1'b0;
    bus.dbg_vld = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_asrt = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FFFF;
    rst = 1'b0;
    bus.clr_req = 1'b0;
    bus.dbg_vld = 1'b0; bus.dbg_ax = '0; bus.dbg_x = '0;
    cpu_acc(1'b1, OP_WD, 32'h40, 32'h5555_5555, 32'h1);

    // Reset holds the port off while still sampling CPU store intent
    step();
    #2;
    chk("rst_en", 32'(bus.dm_en), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h1);
    chk("rst_rdy", 32'(bus.dbg_rdy), 32'h0);
    step();
    rst = 1'b1;

`ifndef DM_INIT_SKIP_EN
    clear_run(-1, 7);
    #2;
    chk("post_clr_ctl", 32'({bus.stall, bus.busy}), 32'b00);
    chk("mem0", mem[0], 32'h0);
    chk("mem1023", mem[1023], 32'h0);
`else
    cpu_idle();
    bus.dbg_vld = 1'b1; bus.dbg_ax = 32'h8; bus.dbg_x = 32'hCAFE_0001;
    #2;
    chk("skip_ctl", 32'({bus.stall, bus.busy}), 32'b00);
    chk("skip_rdy", 32'(bus.dbg_rdy), 32'h1);
    chk("skip_en", 32'(bus.dm_en), 32'h1);
    step();
    bus.dbg_vld = 1'b0;
    #2;
    chk("skip_dbg_mem", ld(32'h8, OP_WD), 32'hCAFE_0001);
`endif

    // Pass-through half-word store
    cpu_acc(1'b1, OP_HF, 32'h22, 32'h1234_BEEF, 32'h3000);
    #2;
    chk("pt_ax", bus.dm_ax, 32'h22);
    chk("pt_x", bus.dm_x, 32'h1234_BEEF);
    chk("pt_op", 32'(bus.dm_op), 32'(OP_HF));
    chk("pt_ctl", 32'({bus.dm_en, bus.stall, bus.busy, bus.dbg_rdy}), 32'b1000);
    chk("pt_pcw", bus.dm_pcw, 32'h3000);
    step();
    cpu_acc(1'b0, OP_UHF, 32'h22, 32'h0, 32'h3004);
    #2;
    chk("ld_uhf", ld(bus.dm_ax, bus.dm_op), 32'h0000_BEEF);
    chk("ld_en", 32'(bus.dm_en), 32'h0);
    step();
    cpu_acc(1'b1, OP_WD, 32'h10, 32'hDEAD_BEEF, 32'h3008);
    step();
    cpu_acc(1'b0, OP_WD, 32'h10, 32'h0, 32'h300C);
    #2;
    chk("ld_wd", ld(bus.dm_ax, bus.dm_op), 32'hDEAD_BEEF);

    // Re-clear on request; clr_req inside the clear is ignored
    step();
    cpu_idle();
    bus.clr_req = 1'b1;
    #2;
    chk("req_busy", 32'(bus.busy), 32'h0);
    step();
    clear_run(5, -1);
    cpu_acc(1'b0, OP_WD, 32'h10, 32'h0, 32'h3010);
    #2;
    chk("reclr_ld", ld(bus.dm_ax, bus.dm_op), 32'h0);
    chk("reclr_hf", ld(32'h20, OP_WD), 32'h0);

    // Debug write beats a coincident CPU store, which replays next cycle
    step();
    cpu_acc(1'b1, OP_BT, 32'h3, 32'h0000_00AB, 32'h4000);
    bus.dbg_vld = 1'b1; bus.dbg_ax = 32'h102; bus.dbg_x = 32'h1234_5678;
    #2;
    chk("dbg_ctl", 32'({bus.dbg_rdy, bus.stall, bus.busy, bus.dm_en}), 32'b1101);
    chk("dbg_ax", bus.dm_ax, 32'h100);
    chk("dbg_x", bus.dm_x, 32'h1234_5678);
    chk("dbg_op", 32'(bus.dm_op), 32'(OP_WD));
    chk("dbg_pcw", bus.dm_pcw, 32'h0);
    step();
    bus.dbg_vld = 1'b0;
    #2;
    chk("replay_ctl", 32'({bus.dbg_rdy, bus.stall, bus.dm_en}), 32'b001);
    chk("replay_ax", bus.dm_ax, 32'h3);
    step();
    cpu_acc(1'b0, OP_UBT, 32'h3, 32'h0, 32'h4004);
    #2;
    chk("ld_ubt", ld(bus.dm_ax, bus.dm_op), 32'h0000_00AB);
    chk("ld_bt", ld(32'h3, OP_BT), 32'hFFFF_FFAB);
    chk("ld_w0", ld(32'h0, OP_WD), 32'hAB00_0000);
    chk("ld_dbg", ld(32'h100, OP_WD), 32'h1234_5678);
    step();
    cpu_idle();
    bus.dbg_vld = 1'b1; bus.dbg_ax = 32'h200; bus.dbg_x = 32'h0000_0042;
    #2;
    chk("dbg_nocpu", 32'({bus.dbg_rdy, bus.stall}), 32'b10);
    step();
    bus.dbg_vld = 1'b0;

`ifndef DM_INIT_SKIP_EN
    // Reset in the middle of a clear restarts it from word 0
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 500; i++) step();
    #2;
    chk("mid_ax", bus.dm_ax, 32'h7D0);
    rst = 1'b0;
    #1;
    chk("mid_rst", 32'({bus.dm_en, bus.stall, bus.busy}), 32'b011);
    step();
    rst = 1'b1;
    #2;
    chk("restart_ax", bus.dm_ax, 32'h0);
    chk("restart_ctl", 32'({bus.dm_en, bus.busy}), 32'b11);
    for (int i = 0; i < 1023; i++) step();
    #2;
    chk("restart_last", bus.dm_ax, 32'hFFC);
    chk("restart_busy", 32'(bus.busy), 32'h1);
    step();
    #2;
    chk("restart_done", 32'({bus.stall, bus.busy}), 32'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
